// File: rtl/prog_mod_counter_pkg.sv
// Shared types and helpers for the programmable modulus counter.
// sat_to_mod works on a fixed wide operand so any counter width up to MAX_W can use it.
package prog_mod_counter_pkg;

    localparam int unsigned MAX_W = 32;

    typedef enum logic {
        RUN  = 1'b0,
        DONE = 1'b1
    } state_t;

    // Clamp a value into the legal count range [0, m-1]; m is never zero.
    function automatic logic [MAX_W-1:0] sat_to_mod(
        input logic [MAX_W-1:0] value,
        input logic [MAX_W-1:0] m
    );
        return (value >= m) ? (m - MAX_W'(1)) : value;
    endfunction

endpackage

// File: rtl/mod_shadow_reg.sv
// Shadow register for the counter modulus: holds a pending value until the
// counter reaches a boundary, and flags rejected zero-modulus writes.
module mod_shadow_reg
    import prog_mod_counter_pkg::*;
#(
    parameter int unsigned W         = 8,
    parameter int unsigned RESET_VAL = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_m_wr,
    input  logic [W-1:0] i_m_in,
    input  logic         i_apply,
    input  logic         i_clr_err,
    output logic [W-1:0] o_pend,
    output logic         o_pend_valid,
    output logic         o_m_err
);

    logic [W-1:0] r_pend;
    logic         r_pend_valid;
    logic         r_m_err;
    logic         w_wr_ok;
    logic         w_wr_bad;

    assign w_wr_ok  = i_m_wr & (i_m_in != '0);
    assign w_wr_bad = i_m_wr & (i_m_in == '0);

    // A write landing in the same cycle as an apply becomes the next pending value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend       <= W'(RESET_VAL);
            r_pend_valid <= 1'b0;
            r_m_err      <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_pend       <= i_m_in;
                r_pend_valid <= 1'b1;
            end else if (i_apply) begin
                r_pend_valid <= 1'b0;
            end

            if (w_wr_bad) begin
                r_m_err <= 1'b1;
            end else if (i_clr_err) begin
                r_m_err <= 1'b0;
            end
        end
    end

    assign o_pend       = r_pend;
    assign o_pend_valid = r_pend_valid;
    assign o_m_err      = r_m_err;

endmodule

// File: rtl/prog_mod_counter.sv
// W-bit up/down counter with run-time programmable modulus, clear, load and
// one-shot mode. Modulus updates are deferred to a period boundary.
module prog_mod_counter
    import prog_mod_counter_pkg::*;
#(
    parameter int unsigned W         = 8,
    parameter int unsigned M_DEFAULT = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         up,
    input  logic         oneshot,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         m_wr,
    input  logic [W-1:0] m_in,
    output logic [W-1:0] q,
    output logic [W-1:0] m_cur,
    output logic         max_tick,
    output logic         min_tick,
    output logic         wrap,
    output logic         done,
    output logic         m_err
);

    state_t       r_state;
    state_t       w_state_next;
    logic [W-1:0] r_q;
    logic [W-1:0] r_m_cur;
    logic         r_done;
    logic [W-1:0] w_q_next;
    logic [W-1:0] w_m_next;
    logic         w_done_next;
    logic [W-1:0] w_m_max;
    logic [W-1:0] w_m_next_max;
    logic [W-1:0] w_q_sat;
    logic [W-1:0] w_load_sat;
    logic [W-1:0] w_pend;
    logic         w_pend_valid;
    logic         w_m_err;
    logic         w_run;
    logic         w_max;
    logic         w_min;
    logic         w_wrap;
    logic         w_apply;

    mod_shadow_reg #(
        .W        (W),
        .RESET_VAL(M_DEFAULT)
    ) u_shadow (
        .clk         (clk),
        .reset       (reset),
        .i_m_wr      (m_wr),
        .i_m_in      (m_in),
        .i_apply     (w_apply),
        .i_clr_err   (clr),
        .o_pend      (w_pend),
        .o_pend_valid(w_pend_valid),
        .o_m_err     (w_m_err)
    );

    assign w_run   = (r_state == RUN);
    assign w_m_max = r_m_cur - W'(1);
    assign w_max   = (r_q == w_m_max);
    assign w_min   = (r_q == '0);
    assign w_wrap  = en & w_run & ~clr & ~load & (up ? w_max : w_min);

    // Pending modulus lands at a period boundary, on clear, or while parked in DONE.
    assign w_apply      = w_pend_valid & (clr | (~load & (w_wrap | ~w_run)));
    assign w_m_next     = w_apply ? w_pend : r_m_cur;
    assign w_m_next_max = w_m_next - W'(1);
    assign w_q_sat      = W'(sat_to_mod(MAX_W'(r_q), MAX_W'(w_m_next)));
    assign w_load_sat   = W'(sat_to_mod(MAX_W'(load_val), MAX_W'(r_m_cur)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (clr || load) begin
            w_state_next = RUN;
        end else if (w_wrap && oneshot) begin
            w_state_next = DONE;
        end
    end

    // Count datapath; a one-shot terminal count holds q instead of wrapping.
    always_comb begin
        w_q_next    = r_q;
        w_done_next = r_done;
        if (clr) begin
            w_q_next    = up ? '0 : w_m_next_max;
            w_done_next = 1'b0;
        end else if (load) begin
            w_q_next    = w_load_sat;
            w_done_next = 1'b0;
        end else if (w_wrap) begin
            if (oneshot) begin
                w_q_next    = w_q_sat;
                w_done_next = 1'b1;
            end else begin
                w_q_next = up ? '0 : w_m_next_max;
            end
        end else if (en && w_run) begin
            w_q_next = up ? (r_q + W'(1)) : (r_q - W'(1));
        end else begin
            w_q_next = w_q_sat;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q     <= '0;
            r_m_cur <= W'(M_DEFAULT);
            r_done  <= 1'b0;
        end else begin
            r_q     <= w_q_next;
            r_m_cur <= w_m_next;
            r_done  <= w_done_next;
        end
    end

    assign q        = r_q;
    assign m_cur    = r_m_cur;
    assign max_tick = w_max;
    assign min_tick = w_min;
    assign wrap     = w_wrap;
    assign done     = r_done;
    assign m_err    = w_m_err;

endmodule

// File: tb/tb_prog_mod_counter.sv
// Bench for prog_mod_counter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against an arithmetic model.
module tb_prog_mod_counter;

    localparam int unsigned W     = 8;
    localparam int unsigned M_DEF = 10;

    logic         clk = 1'b0;
    logic         reset;
    logic         en, up, oneshot, clr, load, m_wr;
    logic [W-1:0] load_val, m_in;
    logic [W-1:0] q, m_cur;
    logic         max_tick, min_tick, wrap, done, m_err;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 1'b0;
    bit rnd_rst = 1'b0;

    // Model state: count, active modulus, pending modulus, flags.
    int mq    = 0;
    int mm    = M_DEF;
    int mpend = M_DEF;
    bit mpv   = 1'b0;
    bit merr  = 1'b0;
    bit mstop = 1'b0;
    bit m_w, m_apply;
    int m_nm;

    prog_mod_counter #(.W(W), .M_DEFAULT(M_DEF)) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .up      (up),
        .oneshot (oneshot),
        .clr     (clr),
        .load    (load),
        .load_val(load_val),
        .m_wr    (m_wr),
        .m_in    (m_in),
        .q       (q),
        .m_cur   (m_cur),
        .max_tick(max_tick),
        .min_tick(min_tick),
        .wrap    (wrap),
        .done    (done),
        .m_err   (m_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_wrap();
        return en && !mstop && !clr && !load && (up ? (mq == mm - 1) : (mq == 0));
    endfunction

    // Reference model: next state from the rules, using modular arithmetic.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq = 0; mm = M_DEF; mpend = M_DEF; mpv = 0; merr = 0; mstop = 0;
        end else begin
            m_w     = model_wrap();
            m_apply = mpv && (clr || (!load && (m_w || mstop)));
            m_nm    = m_apply ? mpend : mm;
            if (m_apply) mpv = 0;
            if (clr) merr = 0;
            if (m_wr) begin
                if (m_in != 0) begin
                    mpend = int'(m_in);
                    mpv   = 1;
                end else begin
                    merr = 1;
                end
            end
            if (clr) begin
                mq    = up ? 0 : m_nm - 1;
                mstop = 0;
            end else if (load) begin
                mq    = (int'(load_val) >= mm) ? mm - 1 : int'(load_val);
                mstop = 0;
            end else if (m_w && oneshot) begin
                mstop = 1;
                if (mq >= m_nm) mq = m_nm - 1;
            end else if (m_w) begin
                mq = up ? 0 : m_nm - 1;
            end else if (en && !mstop) begin
                mq = up ? (mq + 1) % mm : (mq + mm - 1) % mm;
            end else if (mq >= m_nm) begin
                mq = m_nm - 1;
            end
            mm = m_nm;
        end
    end

    // Every-cycle comparison against the model, well away from the clock edge.
    always @(negedge clk) begin
        #2;
        if (chk_on) begin
            check("q",        32'(q),        mq);
            check("m_cur",    32'(m_cur),    mm);
            check("done",     32'(done),     32'(mstop));
            check("m_err",    32'(m_err),    32'(merr));
            check("max_tick", 32'(max_tick), 32'(mq == mm - 1));
            check("min_tick", 32'(min_tick), 32'(mq == 0));
            check("wrap",     32'(wrap),     32'(model_wrap()));
        end
    end

    task automatic go(input bit e, input bit u, input bit os, input bit c, input bit l,
                      input int lv, input bit mw, input int mi);
        @(negedge clk);
        #3;
        reset = rnd_rst;
        en = e; up = u; oneshot = os; clr = c; load = l;
        load_val = W'(lv); m_wr = mw; m_in = W'(mi);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        en = 0; up = 1; oneshot = 0; clr = 0; load = 0; m_wr = 0;
        load_val = '0; m_in = '0;
        repeat (2) @(negedge clk);
        chk_on = 1'b1;
        #3;
        check("rst_q",    32'(q),     0);
        check("rst_mcur", 32'(m_cur), 10);
        check("rst_done", 32'(done),  0);
        check("rst_merr", 32'(m_err), 0);
        reset = 1'b0;

        // Free-running up count, default modulus 10
        for (int i = 0; i < 25; i++) begin
            go(1, 1, 0, 0, 0, 0, 0, 0);
            check("up_q",    32'(q),        i % 10);
            check("up_wrap", 32'(wrap),     32'(i % 10 == 9));
            check("up_max",  32'(max_tick), 32'(i % 10 == 9));
            check("up_min",  32'(min_tick), 32'(i % 10 == 0));
        end

        // Down count from 0, then direction flip at q=5
        go(1, 1, 0, 1, 0, 0, 0, 0);
        for (int k = 0; k < 15; k++) begin
            go(1, 0, 0, 0, 0, 0, 0, 0);
            check("dn_q",    32'(q),    (20 - k) % 10);
            check("dn_wrap", 32'(wrap), 32'((20 - k) % 10 == 0));
        end
        go(1, 1, 0, 0, 0, 0, 0, 0);
        check("flip_q5", 32'(q), 5);
        go(1, 1, 0, 0, 0, 0, 0, 0);
        check("flip_q6", 32'(q), 6);

        // Shadowed modulus write of 4 at q=2
        go(0, 1, 0, 1, 0, 0, 0, 0);
        go(1, 1, 0, 0, 0, 0, 0, 0);
        go(1, 1, 0, 0, 0, 0, 0, 0);
        go(1, 1, 0, 0, 0, 0, 1, 4);
        check("sh_q2", 32'(q), 2);
        for (int v = 3; v <= 9; v++) begin
            go(1, 1, 0, 0, 0, 0, 0, 0);
            check("sh_q_old", 32'(q),     v);
            check("sh_m_old", 32'(m_cur), 10);
        end
        for (int j = 0; j < 5; j++) begin
            go(1, 1, 0, 0, 0, 0, 0, 0);
            check("sh_q_new", 32'(q),     j % 4);
            check("sh_m_new", 32'(m_cur), 4);
        end
        go(0, 1, 0, 0, 0, 0, 1, 0);
        go(0, 1, 0, 0, 0, 0, 0, 0);
        check("err_set",  32'(m_err), 1);
        check("err_mcur", 32'(m_cur), 4);
        go(0, 1, 0, 1, 0, 0, 0, 0);
        go(0, 1, 0, 0, 0, 0, 0, 0);
        check("err_clr", 32'(m_err), 0);

        // One-shot with modulus 5, then saturating load
        go(0, 1, 0, 0, 0, 0, 1, 5);
        go(0, 1, 0, 1, 0, 0, 0, 0);
        for (int p = 0; p < 5; p++) begin
            go(1, 1, 1, 0, 0, 0, 0, 0);
            check("os_q",    32'(q),    p);
            check("os_wrap", 32'(wrap), 32'(p == 4));
            check("os_done", 32'(done), 0);
        end
        repeat (2) begin
            go(1, 1, 1, 0, 0, 0, 0, 0);
            check("os_hold_q",    32'(q),    4);
            check("os_hold_done", 32'(done), 1);
            check("os_hold_wrap", 32'(wrap), 0);
        end
        go(1, 1, 0, 0, 1, 7, 0, 0);
        go(1, 1, 0, 0, 0, 0, 0, 0);
        check("ld_q",    32'(q),    4);
        check("ld_done", 32'(done), 0);
        check("ld_wrap", 32'(wrap), 1);
        go(1, 1, 0, 0, 0, 0, 0, 0);
        check("ld_wrapq", 32'(q), 0);

        // Simultaneous clr, load and modulus write at q=6
        go(0, 1, 0, 0, 0, 0, 1, 10);
        go(0, 1, 0, 1, 0, 0, 0, 0);
        for (int r = 0; r < 6; r++) begin
            go(1, 1, 0, 0, 0, 0, r == 5, 8);
            check("sim_pre_q", 32'(q), r);
        end
        go(1, 1, 0, 1, 1, 2, 1, 3);
        check("sim_q6", 32'(q), 6);
        go(1, 1, 0, 0, 0, 0, 0, 0);
        check("sim_clr_q", 32'(q),     0);
        check("sim_m8",    32'(m_cur), 8);
        for (int s = 1; s <= 7; s++) begin
            go(1, 1, 0, 0, 0, 0, 0, 0);
            check("sim_q_m8", 32'(q),     s);
            check("sim_m_m8", 32'(m_cur), 8);
        end
        go(1, 1, 0, 0, 0, 0, 0, 0);
        check("sim_q_m3", 32'(q),     0);
        check("sim_m3",   32'(m_cur), 3);

        // Asynchronous reset at q=7, between clock edges
        go(0, 1, 0, 0, 0, 0, 1, 10);
        go(0, 1, 0, 1, 0, 0, 0, 0);
        for (int t = 0; t < 7; t++) begin
            go(1, 1, 0, 0, 0, 0, 0, 0);
        end
        @(negedge clk);
        #1;
        check("ar_pre_q", 32'(q), 7);
        #2;
        reset = 1'b1;
        #1;
        check("ar_q",    32'(q),     0);
        check("ar_mcur", 32'(m_cur), 10);
        check("ar_done", 32'(done),  0);
        @(negedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("ar_rel_q", 32'(q), 0);
        go(1, 1, 0, 0, 0, 0, 0, 0);
        check("ar_first", 32'(q), 1);

        // Randomized traffic; the every-cycle checker does the comparing
        for (int n = 0; n < 3000; n++) begin
            rnd_rst = ($urandom_range(0, 499) == 0);
            go($urandom_range(0, 9) != 0,
               $urandom_range(0, 1) == 1,
               $urandom_range(0, 4) == 0,
               $urandom_range(0, 39) == 0,
               $urandom_range(0, 29) == 0,
               int'($urandom_range(0, 20)),
               $urandom_range(0, 19) == 0,
               ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 16)));
        end
        rnd_rst = 1'b0;
        go(0, 1, 0, 0, 0, 0, 0, 0);
        go(0, 1, 0, 0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
